mod_arbiter: RTL and testbench

Round-robin controller that shares one 32-bit modulo unit among NUM_REQ requesters. It latches one requester's operands and pulses the unit's start. It then waits for done and returns the remainder to that requester with a one-cycle ack. It sits between the client blocks and the Mod_32Bit instance, and is the only driver of that unit's start/a/b inputs.

---
 rtl/mod_arbiter.sv | 130 +++++++++++++
 tb/tb_mod_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mod_arbiter.sv
// Round-robin front end sharing one 32-bit modulo unit among NUM_REQ requesters.
// Optional WAIT watchdog is compiled in with `define MOD_ARB_TIMEOUT_EN.
module mod_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int IDX_W       = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [NUM_REQ-1:0]      i_req,
  input  logic [32*NUM_REQ-1:0]   i_req_a,
  input  logic [32*NUM_REQ-1:0]   i_req_b,
  output logic [NUM_REQ-1:0]      o_ack,
  output logic [31:0]             o_rsp_result,
  output logic                    o_rsp_err,
  output logic                    o_busy,
  output logic [IDX_W-1:0]        o_grant_idx,
  output logic                    o_mod_start,
  output logic [31:0]             o_mod_a,
  output logic [31:0]             o_mod_b,
  input  logic [31:0]             i_mod_result,
  input  logic                    i_mod_done
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                     r_state, w_next;
  logic [IDX_W-1:0]           r_last, r_grant, w_sel;
  logic                       w_found, w_timeout;
  logic [NUM_REQ-1:0]         r_ack;
  logic [31:0]                r_result, r_mod_a, r_mod_b;
  logic                       r_busy, r_mod_start;
  logic [NUM_REQ-1:0][31:0]   w_a, w_b;

  assign w_a = i_req_a;
  assign w_b = i_req_b;

  // Rotating priority: scan upward from the slot after the last one acked.
  always_comb begin : p_arb
    int j;
    j       = 0;
    w_found = 1'b0;
    w_sel   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = int'(r_last) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!w_found && i_req[IDX_W'(j)]) begin
        w_found = 1'b1;
        w_sel   = IDX_W'(j);
      end
    end
  end

`ifdef MOD_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == S_ISSUE)     r_cnt <= '0;
      else if (r_state == S_WAIT) r_cnt <= r_cnt + 1'b1;
      if (r_state == S_WAIT && (i_mod_done || w_timeout)) r_err <= !i_mod_done;
    end
  end

  // Fires on the last of TIMEOUT_CYC WAIT cycles; a done in that cycle still wins.
  assign w_timeout = (r_state == S_WAIT) && !i_mod_done &&
                     (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign o_rsp_err = r_err;
`else
  assign w_timeout = 1'b0;
  assign o_rsp_err = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (i_mod_done || w_timeout) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_last      <= IDX_W'(NUM_REQ - 1);
      r_grant     <= '0;
      r_ack       <= '0;
      r_result    <= '0;
      r_busy      <= 1'b0;
      r_mod_start <= 1'b0;
      r_mod_a     <= '0;
      r_mod_b     <= '0;
    end else begin
      r_state     <= w_next;
      r_busy      <= (w_next != S_IDLE);
      r_mod_start <= (r_state == S_IDLE) && w_found;
      r_ack       <= '0;
      case (r_state)
        S_IDLE: if (w_found) begin
          r_grant <= w_sel;
          r_mod_a <= w_a[w_sel];
          r_mod_b <= w_b[w_sel];
        end
        S_WAIT: if (i_mod_done || w_timeout) begin
          r_result <= i_mod_done ? i_mod_result : 32'd0;
          r_ack    <= NUM_REQ'(1) << r_grant;
        end
        S_RESP: r_last <= r_grant;
        default: ;
      endcase
    end
  end

  assign o_ack        = r_ack;
  assign o_rsp_result = r_result;
  assign o_busy       = r_busy;
  assign o_grant_idx  = r_grant;
  assign o_mod_start  = r_mod_start;
  assign o_mod_a      = r_mod_a;
  assign o_mod_b      = r_mod_b;

endmodule

// File: tb/tb_mod_arbiter.sv
// Directed bench for mod_arbiter; the bench plays the modulo unit with a chosen latency.
module tb_mod_arbiter;
  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  logic                  clk = 1'b0;
  logic                  i_rst;
  logic [NUM_REQ-1:0]    i_req;
  logic [32*NUM_REQ-1:0] i_req_a, i_req_b;
  logic [NUM_REQ-1:0]    o_ack;
  logic [31:0]           o_rsp_result, o_mod_a, o_mod_b, i_mod_result;
  logic                  o_rsp_err, o_busy, o_mod_start, i_mod_done;
  logic [IDX_W-1:0]      o_grant_idx;

  int checks = 0;
  int errors = 0;

  mod_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W), .TIMEOUT_CYC(64)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_req(i_req), .i_req_a(i_req_a), .i_req_b(i_req_b),
    .o_ack(o_ack), .o_rsp_result(o_rsp_result), .o_rsp_err(o_rsp_err), .o_busy(o_busy),
    .o_grant_idx(o_grant_idx), .o_mod_start(o_mod_start), .o_mod_a(o_mod_a),
    .o_mod_b(o_mod_b), .i_mod_result(i_mod_result), .i_mod_done(i_mod_done));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_slot(input int i, input logic [31:0] a, input logic [31:0] b);
    i_req_a[32*i +: 32] = a;
    i_req_b[32*i +: 32] = b;
  endtask

  // Call from an IDLE cycle with req already driven; returns in the IDLE cycle after the ack.
  task automatic txn(input string tag, input int lat, input int g,
                     input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] er);
    step();
    chk({tag, " start"}, {31'd0, o_mod_start}, 32'd1);
    chk({tag, " grant"}, {30'd0, o_grant_idx}, g);
    chk({tag, " mod_a"}, o_mod_a, ea);
    chk({tag, " mod_b"}, o_mod_b, eb);
    step();
    chk({tag, " start_pulse"}, {31'd0, o_mod_start}, 32'd0);
    for (int i = 0; i < lat; i++) begin
      chk({tag, " early_ack"}, {28'd0, o_ack}, 32'd0);
      step();
    end
    i_mod_result = (o_mod_b != 0) ? o_mod_a % o_mod_b : 32'd0;
    i_mod_done   = 1'b1;
    step();
    i_mod_done   = 1'b0;
    i_mod_result = 32'd0;
    chk({tag, " ack"}, {28'd0, o_ack}, 32'd1 << g);
    chk({tag, " result"}, o_rsp_result, er);
    chk({tag, " err"}, {31'd0, o_rsp_err}, 32'd0);
    i_req[g] = 1'b0;
    step();
    chk({tag, " ack_clr"}, {28'd0, o_ack}, 32'd0);
    chk({tag, " idle"}, {31'd0, o_busy}, 32'd0);
  endtask

  initial begin
    i_rst = 1'b1; i_req = '0; i_req_a = '0; i_req_b = '0;
    i_mod_done = 1'b0; i_mod_result = '0;
    step(); step();
    chk("rst ack", {28'd0, o_ack}, 0);
    chk("rst busy", {31'd0, o_busy}, 0);
    chk("rst grant", {30'd0, o_grant_idx}, 0);
    chk("rst start", {31'd0, o_mod_start}, 0);
    chk("rst mod_a", o_mod_a, 0);
    chk("rst mod_b", o_mod_b, 0);
    chk("rst result", o_rsp_result, 0);
    chk("rst err", {31'd0, o_rsp_err}, 0);
    i_rst = 1'b0;
    step();

    // single request
    set_slot(0, 17, 5);
    i_req = 4'b0001;
    txn("single", 1, 0, 17, 5, 2);

    // all four after a fresh reset: 17%5=2, 101%7=3, 1000%9=1, 12346%11=4
    i_rst = 1'b1; step(); i_rst = 1'b0;
    set_slot(1, 101, 7); set_slot(2, 1000, 9); set_slot(3, 12346, 11);
    i_req = 4'b1111;
    txn("all0", 0, 0, 17, 5, 2);
    txn("all1", 2, 1, 101, 7, 3);
    txn("all2", 1, 2, 1000, 9, 1);
    txn("all3", 3, 3, 12346, 11, 4);

    // wrap: serve 2, then 0 and 2 both request -> 0 first
    i_req = 4'b0100;
    txn("pre2", 0, 2, 1000, 9, 1);
    i_req = 4'b0101;
    txn("wrap0", 1, 0, 17, 5, 2);
    txn("wrap2", 0, 2, 1000, 9, 1);

    // operand change and req drop during WAIT: 100%7=2
    set_slot(0, 100, 7);
    i_req = 4'b0001;
    step();
    chk("mid mod_a issue", o_mod_a, 100);
    step();
    set_slot(0, 7, 7);
    i_req = 4'b0000;
    step();
    chk("mid mod_a wait", o_mod_a, 100);
    chk("mid mod_b wait", o_mod_b, 7);
    chk("mid busy", {31'd0, o_busy}, 1);
    i_mod_result = o_mod_a % o_mod_b;
    i_mod_done   = 1'b1;
    step();
    i_mod_done = 1'b0;
    chk("mid ack", {28'd0, o_ack}, 4'b0001);
    chk("mid result", o_rsp_result, 2);
    step();
    chk("mid idle", {31'd0, o_busy}, 0);

    // reset while waiting on requester 1; requester 0 then wins
    set_slot(0, 17, 5);
    i_req = 4'b0011;
    step();
    chk("rstw grant", {30'd0, o_grant_idx}, 1);
    step();
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    chk("rstw busy", {31'd0, o_busy}, 0);
    chk("rstw ack", {28'd0, o_ack}, 0);
    chk("rstw grant0", {30'd0, o_grant_idx}, 0);
    chk("rstw mod_a", o_mod_a, 0);
    txn("rstw0", 0, 0, 17, 5, 2);
    txn("rstw1", 1, 1, 101, 7, 3);

    // spurious done while idle
    i_mod_done = 1'b1; i_mod_result = 55;
    step();
    i_mod_done = 1'b0; i_mod_result = 0;
    chk("spur ack", {28'd0, o_ack}, 0);
    chk("spur busy", {31'd0, o_busy}, 0);
    chk("spur start", {31'd0, o_mod_start}, 0);
    step();
    chk("spur ack2", {28'd0, o_ack}, 0);

`ifdef MOD_ARB_TIMEOUT_EN
    i_req = 4'b0100;
    step();
    chk("to grant", {30'd0, o_grant_idx}, 2);
    repeat (64) step();
    chk("to no_ack_63", {28'd0, o_ack}, 0);
    chk("to busy", {31'd0, o_busy}, 1);
    step();
    chk("to ack", {28'd0, o_ack}, 4'b0100);
    chk("to err", {31'd0, o_rsp_err}, 1);
    chk("to result", o_rsp_result, 0);
    i_req = 4'b0000;
    i_mod_done = 1'b1; i_mod_result = 9;
    step();
    i_mod_done = 1'b0;
    chk("to late ack", {28'd0, o_ack}, 0);
    chk("to idle", {31'd0, o_busy}, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
